// File: rtl/de_selector_pkg.sv
// rtl/de_selector_pkg.sv - shared constants and helpers for the registered 1-to-CH selector
package de_selector_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Lowest bit of channel k inside the flattened oData bus.
  function automatic int slotLsb(input int k, input int dw);
    return k * dw;
  endfunction

  // Round-robin successor, wrapping n-1 back to 0.
  function automatic int wrapInc(input int p, input int n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/de_slot.sv
// rtl/de_slot.sv - one-entry holding register for a single output channel
module de_slot #(
  parameter int DW = 8
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iLoad,
  input  logic          iDrain,
  input  logic [DW-1:0] iData,
  output logic          oValid,
  output logic [DW-1:0] oData
);

  // Load wins over drain so a same-cycle drain+load keeps the slot full with the new word.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oValid <= 1'b0;
      oData  <= '0;
    end else if (iLoad) begin
      oValid <= 1'b1;
      oData  <= iData;
    end else if (iDrain) begin
      oValid <= 1'b0;
    end
  end

endmodule

// File: rtl/de_selector_seq.sv
// rtl/de_selector_seq.sv - registered 1-to-CH demultiplexer with explicit or round-robin target
module de_selector_seq
  import de_selector_pkg::*;
#(
  parameter  int CH = 4,
  parameter  int DW = 8,
  localparam int SW = $clog2(CH)
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iMode,
  input  logic [SW-1:0]    iSel,
  input  logic             iValid,
  output logic             oReady,
  input  logic [DW-1:0]    iData,
  output logic [CH-1:0]    oValid,
  input  logic [CH-1:0]    iReady,
  output logic [CH*DW-1:0] oData,
  output logic [SW-1:0]    oPtr
);

  logic [SW-1:0] tgt;
  logic          tgtHit;
  logic          tgtFull;
  logic          tgtReady;
  logic          accept;
  logic [CH-1:0] load;
  logic [CH-1:0] drain;

  assign tgt = (iMode == MODE_RR) ? oPtr : iSel;

  // tgtHit stays low for select codes beyond CH-1, which blocks the input outright.
  always_comb begin
    tgtHit   = 1'b0;
    tgtFull  = 1'b0;
    tgtReady = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (tgt == SW'(k)) begin
        tgtHit   = 1'b1;
        tgtFull  = oValid[k];
        tgtReady = iReady[k];
      end
    end
  end

  assign oReady = iRst_n && tgtHit && (!tgtFull || tgtReady);
  assign accept = iValid && oReady;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oPtr <= '0;
    end else if (accept && (iMode == MODE_RR)) begin
      oPtr <= SW'(wrapInc(int'(oPtr), CH));
    end
  end

  for (genvar k = 0; k < CH; k++) begin : gSlot
    localparam int LSB = slotLsb(k, DW);

    assign load[k]  = accept && (tgt == SW'(k));
    assign drain[k] = oValid[k] && iReady[k];

    de_slot #(
      .DW(DW)
    ) uSlot (
      .iClk  (iClk),
      .iRst_n(iRst_n),
      .iLoad (load[k]),
      .iDrain(drain[k]),
      .iData (iData),
      .oValid(oValid[k]),
      .oData (oData[LSB +: DW])
    );
  end

endmodule

// File: tb/tb_de_selector_seq.sv
// tb/tb_de_selector_seq.sv - self-checking bench for de_selector_seq (CH=4 and CH=3 instances)
module tb_de_selector_seq;
  import de_selector_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        mode;
  logic [1:0]  sel;
  logic        valid;
  logic [7:0]  data;
  logic [3:0]  rdy;
  logic        oRdy;
  logic [3:0]  oVal;
  logic [31:0] oDat;
  logic [1:0]  oPtr;

  logic        mode3;
  logic [1:0]  sel3;
  logic        valid3;
  logic [7:0]  data3;
  logic [2:0]  rdy3;
  logic        oRdy3;
  logic [2:0]  oVal3;
  logic [23:0] oDat3;
  logic [1:0]  oPtr3;

  de_selector_seq #(.CH(4), .DW(8)) dut (
    .iClk(clk), .iRst_n(rst_n), .iMode(mode), .iSel(sel), .iValid(valid),
    .oReady(oRdy), .iData(data), .oValid(oVal), .iReady(rdy), .oData(oDat), .oPtr(oPtr)
  );

  de_selector_seq #(.CH(3), .DW(8)) dut3 (
    .iClk(clk), .iRst_n(rst_n), .iMode(mode3), .iSel(sel3), .iValid(valid3),
    .oReady(oRdy3), .iData(data3), .oValid(oVal3), .iReady(rdy3), .oData(oDat3), .oPtr(oPtr3)
  );

  int total = 0;
  int bad = 0;

  // Reference: a channel is a box that is either empty or holds one word.
  bit         mValid[4];
  logic [7:0] mData[4];
  int         mPtr;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic        valid;
    logic [7:0]  data;
    logic [3:0]  rdy;
    logic        expRdy;
    logic [3:0]  expVal;
    logic [31:0] expDat;
    logic [1:0]  expPtr;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int modelTarget();
    return (mode == MODE_RR) ? mPtr : int'(sel);
  endfunction

  function automatic bit modelReady();
    int t = modelTarget();
    return (t < 4) && (!mValid[t] || rdy[t]);
  endfunction

  function automatic logic [3:0] modelValid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = mValid[k];
    return v;
  endfunction

  function automatic logic [31:0] modelData();
    return {mData[3], mData[2], mData[1], mData[0]};
  endfunction

  task automatic modelStep();
    int t   = modelTarget();
    bit acc = valid && modelReady();
    for (int k = 0; k < 4; k++) if (mValid[k] && rdy[k]) mValid[k] = 1'b0;
    if (acc) begin
      mValid[t] = 1'b1;
      mData[t]  = data;
      if (mode == MODE_RR) mPtr = (mPtr + 1) % 4;
    end
  endtask

  task automatic modelClear();
    for (int k = 0; k < 4; k++) begin
      mValid[k] = 1'b0;
      mData[k]  = 8'h00;
    end
    mPtr = 0;
  endtask

  // Entered at posedge+1 with inputs already applied; leaves at the next posedge+1.
  task automatic runCycle(input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, oRdy}, {31'd0, modelReady()});
    modelStep();
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, {28'd0, oVal}, {28'd0, modelValid()});
    chk({tag, "_data"}, oDat, modelData());
    chk({tag, "_ptr"}, {30'd0, oPtr}, 32'(mPtr));
  endtask

  task automatic asyncReset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {28'd0, oVal}, 32'd0);
    chk("arst_data", oDat, 32'd0);
    chk("arst_ptr", {30'd0, oPtr}, 32'd0);
    chk("arst_ready", {31'd0, oRdy}, 32'd0);
    chk("arst_valid3", {29'd0, oVal3}, 32'd0);
    modelClear();
    @(posedge clk);
    #1;
    chk("arst_hold_valid", {28'd0, oVal}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    mode = MODE_SEL; sel = 2'd0; valid = 1'b0; data = 8'h00; rdy = 4'h0;
    mode3 = MODE_SEL; sel3 = 2'd0; valid3 = 1'b0; data3 = 8'h00; rdy3 = 3'h0;
    modelClear();

    vecs[0]  = '{1'b0, 2'd2, 1'b1, 8'hA5, 4'b0000, 1'b1, 4'b0100, 32'h00A50000, 2'd0};
    vecs[1]  = '{1'b0, 2'd2, 1'b1, 8'h77, 4'b0000, 1'b0, 4'b0100, 32'h00A50000, 2'd0};
    vecs[2]  = '{1'b0, 2'd2, 1'b1, 8'h3C, 4'b0100, 1'b1, 4'b0100, 32'h003C0000, 2'd0};
    vecs[3]  = '{1'b0, 2'd2, 1'b0, 8'h00, 4'b0100, 1'b1, 4'b0000, 32'h003C0000, 2'd0};
    vecs[4]  = '{1'b1, 2'd0, 1'b1, 8'h10, 4'b1111, 1'b1, 4'b0001, 32'h003C0010, 2'd1};
    vecs[5]  = '{1'b1, 2'd0, 1'b1, 8'h11, 4'b1111, 1'b1, 4'b0010, 32'h003C1110, 2'd2};
    vecs[6]  = '{1'b1, 2'd0, 1'b1, 8'h12, 4'b1111, 1'b1, 4'b0100, 32'h00121110, 2'd3};
    vecs[7]  = '{1'b1, 2'd0, 1'b1, 8'h13, 4'b1111, 1'b1, 4'b1000, 32'h13121110, 2'd0};
    vecs[8]  = '{1'b1, 2'd0, 1'b1, 8'h14, 4'b1111, 1'b1, 4'b0001, 32'h13121114, 2'd1};
    vecs[9]  = '{1'b1, 2'd0, 1'b1, 8'h15, 4'b1111, 1'b1, 4'b0010, 32'h13121514, 2'd2};
    vecs[10] = '{1'b1, 2'd0, 1'b1, 8'h20, 4'b1101, 1'b1, 4'b0110, 32'h13201514, 2'd3};
    vecs[11] = '{1'b1, 2'd0, 1'b1, 8'h21, 4'b1101, 1'b1, 4'b1010, 32'h21201514, 2'd0};
    vecs[12] = '{1'b1, 2'd0, 1'b1, 8'h22, 4'b1101, 1'b1, 4'b0011, 32'h21201522, 2'd1};
    vecs[13] = '{1'b1, 2'd0, 1'b1, 8'h23, 4'b1101, 1'b0, 4'b0010, 32'h21201522, 2'd1};
    vecs[14] = '{1'b1, 2'd0, 1'b1, 8'h23, 4'b1101, 1'b0, 4'b0010, 32'h21201522, 2'd1};
    vecs[15] = '{1'b1, 2'd0, 1'b1, 8'h23, 4'b1111, 1'b1, 4'b0010, 32'h21202322, 2'd2};
    vecs[16] = '{1'b1, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h21202322, 2'd2};
    vecs[17] = '{1'b0, 2'd0, 1'b1, 8'hA0, 4'b0000, 1'b1, 4'b0001, 32'h212023A0, 2'd2};
    vecs[18] = '{1'b0, 2'd1, 1'b1, 8'hA1, 4'b0000, 1'b1, 4'b0011, 32'h2120A1A0, 2'd2};
    vecs[19] = '{1'b0, 2'd3, 1'b1, 8'hA3, 4'b0000, 1'b1, 4'b1011, 32'hA320A1A0, 2'd2};

    @(posedge clk);
    #1;
    chk("reset_valid", {28'd0, oVal}, 32'd0);
    chk("reset_data", oDat, 32'd0);
    chk("reset_ptr", {30'd0, oPtr}, 32'd0);
    chk("reset_ready", {31'd0, oRdy}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      mode = vecs[i].mode; sel = vecs[i].sel; valid = vecs[i].valid;
      data = vecs[i].data; rdy = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), {31'd0, oRdy}, {31'd0, vecs[i].expRdy});
      modelStep();
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), {28'd0, oVal}, {28'd0, vecs[i].expVal});
      chk($sformatf("vec%0d_data", i), oDat, vecs[i].expDat);
      chk($sformatf("vec%0d_ptr", i), {30'd0, oPtr}, {30'd0, vecs[i].expPtr});
    end

    // Mid-stream asynchronous reset with oValid=1011, oPtr=2 and a word still offered.
    mode = MODE_SEL; sel = 2'd0; valid = 1'b1; data = 8'hEE; rdy = 4'h0;
    asyncReset();

    // First accept lands in the first cycle after release.
    mode = MODE_SEL; sel = 2'd1; valid = 1'b1; data = 8'h5A; rdy = 4'h0;
    runCycle("post_rst");

    for (int i = 0; i < 400; i++) begin
      mode  = 1'($urandom_range(0, 1));
      sel   = 2'($urandom);
      valid = ($urandom_range(0, 3) != 0);
      data  = 8'($urandom);
      rdy   = (i % 50 < 10) ? 4'($urandom) & 4'($urandom) : 4'($urandom) | 4'($urandom);
      if (i == 200) asyncReset();
      runCycle("rand");
    end

    // CH=3: an out-of-range select is refused and changes nothing.
    valid = 1'b0;
    mode3 = MODE_SEL; sel3 = 2'd0; valid3 = 1'b1; data3 = 8'h55; rdy3 = 3'b000;
    @(negedge clk);
    chk("ch3_load_ready", {31'd0, oRdy3}, 32'd1);
    @(posedge clk);
    #1;
    chk("ch3_load_valid", {29'd0, oVal3}, 32'd1);
    sel3 = 2'd3; data3 = 8'h99;
    @(negedge clk);
    chk("ch3_sel3_ready", {31'd0, oRdy3}, 32'd0);
    @(posedge clk);
    #1;
    chk("ch3_sel3_valid", {29'd0, oVal3}, 32'd1);
    chk("ch3_sel3_data", {8'd0, oDat3}, 32'h00000055);
    chk("ch3_sel3_ptr", {30'd0, oPtr3}, 32'd0);

    // CH=3 round-robin wraps 2 -> 0.
    mode3 = MODE_RR; rdy3 = 3'b111;
    for (int i = 0; i < 3; i++) begin
      data3 = 8'(i + 1);
      @(posedge clk);
      #1;
      chk($sformatf("ch3_rr%0d_ptr", i), {30'd0, oPtr3}, 32'((i + 1) % 3));
      chk($sformatf("ch3_rr%0d_valid", i), {29'd0, oVal3}, 32'(1 << i));
    end
    chk("ch3_rr_data", {8'd0, oDat3}, 32'h00030201);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
